// File: rtl/cpu16_ctrl.sv
// cpu16_ctrl: multi-cycle control sequencer for the cpu16 datapath.
// Fetches 16-bit instructions over a req/ack handshake into IR, decodes
// ADD/SUB/AND/OR/NOP/HALT and drives the ALU op, register-file addresses
// and write enable through the EXEC and WB phases. Sole owner of PC and IR.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   run        level, enables instruction fetching
//   imem_req   instruction fetch request (FETCH only)
//   imem_addr  fetch address, always the current PC
//   imem_ack   fetch data valid this cycle (only looked at in FETCH)
//   imem_data  fetched instruction word
//   ir         latched instruction register
//   rf_ra      register read address A = ir[11:8]
//   rf_rb      register read address B = ir[3:0]
//   alu_op     one-hot ALU op: bit0 ADD, bit1 SUB, bit2 AND, bit3 OR
//   rf_we      register-file write enable (one cycle, in WB)
//   rf_wa      register-file write address = ir[11:8]
//   busy       high in FETCH, DECODE, EXEC, WB
//   halted     high in HALT
//   err        00 none, 01 illegal instruction, 10 fetch timeout
//
// State table:
//   state  | meaning
//   IDLE   | parked, waiting for run
//   FETCH  | requesting imem[pc], counting wait cycles
//   DECODE | classifying ir
//   EXEC   | alu_op driven
//   WB     | alu_op held, rf_we pulsed
//   HALT   | stopped, err held, only reset leaves

module cpu16_ctrl #(
    parameter logic [15:0] PC_RESET      = 16'h0000,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] ir,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    output logic [3:0]  alu_op,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // The wait cycle that would make the count reach FETCH_TIMEOUT is the
    // one that faults, so compare against the value one below it.
    localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] pc, pc_nx;
    logic [15:0] ir_nx;
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic [1:0]  err_nx;
    logic [3:0]  op_onehot;
    logic        is_alu;
    logic        is_nop;
    logic        is_halt;

    always_comb begin
        op_onehot = 4'b0000;
        case (ir[7:4])
            4'b1010: op_onehot = 4'b0001;
            4'b0010: op_onehot = 4'b0010;
            4'b1100: op_onehot = 4'b0100;
            4'b1110: op_onehot = 4'b1000;
            default: op_onehot = 4'b0000;
        endcase
    end

    assign is_alu  = (ir[15:12] == 4'b0000) && (op_onehot != 4'b0000);
    assign is_nop  = (ir == 16'h0000);
    assign is_halt = (ir[15:12] == 4'b1111);

    assign imem_addr = pc;
    assign rf_ra     = ir[11:8];
    assign rf_rb     = ir[3:0];
    assign rf_wa     = ir[11:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= PC_RESET;
            ir       <= 16'h0000;
            wait_cnt <= 8'd0;
            err      <= ERR_NONE;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= ir_nx;
            wait_cnt <= wait_cnt_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        ir_nx       = ir;
        wait_cnt_nx = wait_cnt;
        err_nx      = err;
        imem_req    = 1'b0;
        alu_op      = 4'b0000;
        rf_we       = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_nx = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ack) begin
                    ir_nx       = imem_data;
                    pc_nx       = pc + 16'd1;
                    wait_cnt_nx = 8'd0;
                    state_nx    = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_nx   = ERR_TIMEOUT;
                    state_nx = S_HALT;
                end else begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                if (is_alu) begin
                    state_nx = S_EXEC;
                end else if (is_nop) begin
                    state_nx = run ? S_FETCH : S_IDLE;
                end else if (is_halt) begin
                    err_nx   = ERR_NONE;
                    state_nx = S_HALT;
                end else begin
                    err_nx   = ERR_ILLEGAL;
                    state_nx = S_HALT;
                end
            end
            S_EXEC: begin
                busy     = 1'b1;
                alu_op   = op_onehot;
                state_nx = S_WB;
            end
            S_WB: begin
                busy     = 1'b1;
                alu_op   = op_onehot;
                rf_we    = 1'b1;
                state_nx = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu16_ctrl.sv
// Testbench for cpu16_ctrl: directed scenarios plus randomized programs and
// ack delays, checked against an instruction-level model of the sequencer.

module tb_cpu16_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic [3:0]  rf_ra, rf_rb, alu_op, rf_wa;
    logic        rf_we, busy, halted;
    logic [1:0]  err;

    // second instance with PC_RESET at the top of the address space
    logic        run_w;
    logic        imem_req_w;
    logic [15:0] imem_addr_w;
    logic        imem_ack_w;
    logic [15:0] imem_data_w;
    logic [15:0] ir_w;
    logic [3:0]  rf_ra_w, rf_rb_w, alu_op_w, rf_wa_w;
    logic        rf_we_w, busy_w, halted_w;
    logic [1:0]  err_w;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] mem [0:255];
    logic [15:0] exp_pc;
    logic [15:0] exp_ir;

    always #5 clk = ~clk;

    cpu16_ctrl #(.PC_RESET(16'h0000), .FETCH_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .rf_ra(rf_ra), .rf_rb(rf_rb), .alu_op(alu_op),
        .rf_we(rf_we), .rf_wa(rf_wa), .busy(busy), .halted(halted), .err(err)
    );

    cpu16_ctrl #(.PC_RESET(16'hFFFF), .FETCH_TIMEOUT(15)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_data(imem_data_w),
        .ir(ir_w), .rf_ra(rf_ra_w), .rf_rb(rf_rb_w), .alu_op(alu_op_w),
        .rf_we(rf_we_w), .rf_wa(rf_wa_w), .busy(busy_w), .halted(halted_w), .err(err_w)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One-hot op per the instruction set; zero means not an ALU function code.
    function automatic logic [3:0] op_of(input logic [15:0] w);
        case (w[7:4])
            4'b1010: return 4'b0001;
            4'b0010: return 4'b0010;
            4'b1100: return 4'b0100;
            4'b1110: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // 0 ALU, 1 NOP, 2 HALT, 3 illegal
    function automatic int kind_of(input logic [15:0] w);
        if (w == 16'h0000) return 1;
        if (w[15:12] == 4'hF) return 2;
        if (w[15:12] == 4'h0 && op_of(w) != 4'b0000) return 0;
        return 3;
    endfunction

    function automatic logic pick_run(input int mode);
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (mode == 2) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_req"}, imem_req, 1'b0);
        check({tag, "_we"}, rf_we, 1'b0);
        check({tag, "_alu"}, alu_op, 4'b0000);
        check({tag, "_halted"}, halted, 1'b0);
    endtask

    task automatic check_halt(input logic [1:0] exp_err);
        check("halt_halted", halted, 1'b1);
        check("halt_busy", busy, 1'b0);
        check("halt_req", imem_req, 1'b0);
        check("halt_we", rf_we, 1'b0);
        check("halt_alu", alu_op, 4'b0000);
        check("halt_err", err, exp_err);
        check("halt_pc", imem_addr, exp_pc);
        check("halt_ir", ir, exp_ir);
    endtask

    task automatic hold_halt(input logic [1:0] exp_err, input int n);
        for (int i = 0; i < n; i++) begin
            run      = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            step();
            check_halt(exp_err);
        end
    endtask

    // Runs one instruction starting with the DUT in FETCH.
    // outcome: 0 back in FETCH, 1 parked in IDLE, 2 halted.
    task automatic do_instr(input int delay, input int run_mode, output int outcome);
        logic [15:0] w;
        logic        r;
        int          k;
        for (int d = 0; ; d++) begin
            check("fetch_req", imem_req, 1'b1);
            check("fetch_addr", imem_addr, exp_pc);
            check("fetch_busy", busy, 1'b1);
            check("fetch_we", rf_we, 1'b0);
            check("fetch_alu", alu_op, 4'b0000);
            if (d == delay) begin
                imem_ack  = 1'b1;
                imem_data = mem[exp_pc[7:0]];
            end else begin
                imem_ack  = 1'b0;
                imem_data = 16'($urandom);
            end
            run = pick_run(run_mode == 2 ? 0 : run_mode);
            step();
            if (d == delay) break;
            if (d == 14) begin
                check_halt(2'b10);
                outcome = 2;
                return;
            end
        end
        w      = mem[exp_pc[7:0]];
        exp_pc = exp_pc + 16'd1;
        exp_ir = w;
        check("dec_busy", busy, 1'b1);
        check("dec_req", imem_req, 1'b0);
        check("dec_we", rf_we, 1'b0);
        check("dec_alu", alu_op, 4'b0000);
        check("dec_ir", ir, w);
        check("dec_ra", rf_ra, w[11:8]);
        check("dec_rb", rf_rb, w[3:0]);
        k         = kind_of(w);
        r         = pick_run(run_mode);
        run       = r;
        imem_ack  = 1'($urandom_range(0, 1));
        imem_data = 16'($urandom);
        step();
        if (k == 1) begin
            outcome = r ? 0 : 1;
            return;
        end
        if (k == 2) begin
            check_halt(2'b00);
            outcome = 2;
            return;
        end
        if (k == 3) begin
            check_halt(2'b01);
            outcome = 2;
            return;
        end
        check("exec_alu", alu_op, op_of(w));
        check("exec_we", rf_we, 1'b0);
        check("exec_busy", busy, 1'b1);
        run      = pick_run(run_mode);
        imem_ack = 1'($urandom_range(0, 1));
        step();
        check("wb_alu", alu_op, op_of(w));
        check("wb_we", rf_we, 1'b1);
        check("wb_wa", rf_wa, w[11:8]);
        check("wb_busy", busy, 1'b1);
        r        = pick_run(run_mode);
        run      = r;
        imem_ack = 1'($urandom_range(0, 1));
        step();
        outcome = r ? 0 : 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        run      = 1'b0;
        imem_ack = 1'b0;
        exp_pc   = 16'h0000;
        exp_ir   = 16'h0000;
        check("rst_we", rf_we, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_err", err, 2'b00);
        check("rst_ir", ir, 16'h0000);
        check("rst_pc", imem_addr, 16'h0000);
        #2;
        rst_n = 1'b1;
        step();
        check_idle("post_rst");
    endtask

    initial begin
        int outcome;
        int c0;
        logic [3:0] fn [0:3];
        fn[0] = 4'b1010; fn[1] = 4'b0010; fn[2] = 4'b1100; fn[3] = 4'b1110;

        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
        run_w = 1'b0; imem_ack_w = 1'b0; imem_data_w = 16'h0000;
        exp_pc = 16'h0000; exp_ir = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        #12;
        do_reset();

        // wrap-around instance: NOP at 16'hFFFF, next fetch from 16'h0000
        run_w = 1'b1; imem_ack_w = 1'b1; imem_data_w = 16'h0000;
        step();
        check("wrap_req0", imem_req_w, 1'b1);
        check("wrap_addr0", imem_addr_w, 16'hFFFF);
        step();
        check("wrap_dec_req", imem_req_w, 1'b0);
        step();
        check("wrap_req1", imem_req_w, 1'b1);
        check("wrap_addr1", imem_addr_w, 16'h0000);
        run_w = 1'b0;
        check_idle("main_idle_during_wrap");

        // ADD R3,R5 zero-wait
        mem[0] = 16'h03A5; mem[1] = 16'h0000;
        run = 1'b1;
        step();
        do_instr(0, 0, outcome);
        check("add_outcome", outcome, 0);
        check("add_next_addr", imem_addr, 16'h0001);

        // SUB/AND/OR then HALT, 14 cycles from first fetch
        do_reset();
        mem[0] = 16'h0122; mem[1] = 16'h04C7; mem[2] = 16'h02E1; mem[3] = 16'hF000;
        run = 1'b1;
        step();
        c0 = cyc;
        for (int i = 0; i < 4; i++) do_instr(0, 0, outcome);
        check("prog_outcome", outcome, 2);
        check("prog_cycles", cyc - c0, 14);
        check("prog_pc", imem_addr, 16'h0004);
        hold_halt(2'b00, 2);

        // illegal word, halt is sticky under run toggling
        do_reset();
        mem[0] = 16'h0050;
        run = 1'b1;
        step();
        do_instr(0, 0, outcome);
        check("ill_outcome", outcome, 2);
        hold_halt(2'b01, 6);
        do_reset();

        // ack delayed 3, then 14 (last legal), then withheld 15 -> timeout
        mem[0] = 16'h03A5; mem[1] = 16'h04C7; mem[2] = 16'h02E1;
        run = 1'b1;
        step();
        do_instr(3, 0, outcome);
        check("dly3_outcome", outcome, 0);
        do_instr(14, 0, outcome);
        check("dly14_outcome", outcome, 0);
        do_instr(15, 0, outcome);
        check("tmo_outcome", outcome, 2);
        check("tmo_pc", imem_addr, 16'h0002);
        hold_halt(2'b10, 3);

        // run drops during EXEC: WB completes, then IDLE
        do_reset();
        mem[0] = 16'h03A5;
        run = 1'b1;
        step();
        do_instr(0, 2, outcome);
        check("rundrop_outcome", outcome, 1);
        check_idle("rundrop_idle");
        step();
        check_idle("rundrop_idle2");

        // reset asserted in WB drops rf_we immediately
        do_reset();
        run = 1'b1;
        step();
        imem_ack = 1'b1; imem_data = 16'h03A5;
        step();
        imem_ack = 1'b0;
        step();
        step();
        check("wbrst_we_before", rf_we, 1'b1);
        #2;
        do_reset();

        // randomized programs
        for (int round = 0; round < 30; round++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                int p;
                p = $urandom_range(0, 99);
                if (p < 70)
                    mem[i] = {4'h0, 4'($urandom), fn[$urandom_range(0, 3)], 4'($urandom)};
                else if (p < 80)
                    mem[i] = 16'h0000;
                else if (p < 88)
                    mem[i] = {4'hF, 12'($urandom)};
                else
                    mem[i] = 16'($urandom);
            end
            run = 1'b1;
            step();
            for (int n = 0; n < 40; n++) begin
                int dly;
                dly = ($urandom_range(0, 99) < 3) ? $urandom_range(14, 15) : $urandom_range(0, 3);
                do_instr(dly, 1, outcome);
                if (outcome == 2) begin
                    hold_halt(err, 0);
                    check("rnd_halted", halted, 1'b1);
                    hold_halt(halted ? err : 2'b11, 2);
                    break;
                end
                if (outcome == 1) begin
                    check_idle("rnd_idle");
                    for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                        run = 1'b0;
                        imem_ack = 1'($urandom_range(0, 1));
                        step();
                        check_idle("rnd_idle_hold");
                    end
                    run = 1'b1;
                    step();
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 2000000);
        $fatal(1);
    end

endmodule
